ibpl_enable_sequencer: RTL and testbench

// - Owns output_enable/input_enable for all interbackplane cardlet slots of the DIOB2 blackbox.
// - Host requests arrive one at a time over a valid/ready handshake and are applied to one slot
//   in a glitch-safe order: drop outputs, settle, switch inputs, settle, raise outputs, check.
// - Checks the slot's plugin_error after each apply. On error the slot goes to all-off and a

---
 rtl/ibpl_seq_pkg.sv | 33 +++
 rtl/ibpl_seq_timer.sv | 35 +++
 rtl/ibpl_enable_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_ibpl_enable_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibpl_seq_pkg.sv
// ibpl_seq_pkg
//   Shared types and constants for the interbackplane enable sequencer.
//   - NUM_SLOTS / CH fix the slot count and the per-slot channel count that
//     every bus in the sequencer is built from.
//   - DEFAULT_SETTLE_CYCLES / DEFAULT_CHECK_CYCLES are the default phase lengths.
//   - seq_state_t lists the sequencer states in the order they are normally walked.
//   - slot_slice() gives the low bit offset of a slot inside a packed enable bus.
package ibpl_seq_pkg;

   localparam int NUM_SLOTS             = 4;
   localparam int CH                    = 6;
   localparam int DEFAULT_SETTLE_CYCLES = 16;
   localparam int DEFAULT_CHECK_CYCLES  = 8;
   localparam int SLOT_W                = $clog2(NUM_SLOTS);

   typedef enum logic [3:0] {
      IDLE,
      REJECT,
      DROP,
      SETTLE_A,
      SWITCH,
      SETTLE_B,
      RAISE,
      CHECK,
      DONE,
      FAULT
   } seq_state_t;

   function automatic int slot_slice(input logic [SLOT_W-1:0] s);
      return int'(s) * CH;
   endfunction

endpackage

// File: rtl/ibpl_seq_timer.sv
// ibpl_seq_timer
//   Loadable down-counter shared by the settle and check phases. Loading N
//   gives N+1 cycles with the counter visible before zero is reached, so the
//   sequencer loads (phase length - 1).
//   Ports:
//   - clk, reset   clock and asynchronous active-high reset
//   - load         load load_val on the next clock
//   - load_val     value to load
//   - zero         counter currently reads zero
module ibpl_seq_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count_q;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/ibpl_enable_sequencer.sv
// ibpl_enable_sequencer
//   Owns output_enable / input_enable for every interbackplane cardlet slot.
//   One host request at a time is applied to one slot in a glitch-safe order:
//   drop outputs, settle, switch inputs, settle, raise outputs, then watch the
//   slot's plugin_error. An error during the check window turns the slot fully
//   off and latches a sticky fault bit.
//   Ports:
//   - clk, reset                  clock and asynchronous active-high reset
//   - req_valid/req_ready         request handshake (ready only in IDLE)
//   - req_slot, req_oe, req_ie    request fields, captured on transfer
//   - resp_valid, resp_err        one-cycle completion pulse and its error flag
//   - fault_clr, fault_mask       per-slot sticky fault clear pulses / state
//   - plugin_error                asynchronous per-slot cardlet error inputs
//   - output_enable/input_enable  slot s occupies bits [s*CH +: CH]
//   - busy                        sequencer is not IDLE
module ibpl_enable_sequencer
   import ibpl_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
   parameter int CHECK_CYCLES  = DEFAULT_CHECK_CYCLES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [SLOT_W-1:0]       req_slot,
   input  logic [CH-1:0]           req_oe,
   input  logic [CH-1:0]           req_ie,
   output logic                    resp_valid,
   output logic                    resp_err,
   input  logic [NUM_SLOTS-1:0]    fault_clr,
   output logic [NUM_SLOTS-1:0]    fault_mask,
   input  logic [NUM_SLOTS-1:0]    plugin_error,
   output logic [NUM_SLOTS*CH-1:0] output_enable,
   output logic [NUM_SLOTS*CH-1:0] input_enable,
   output logic                    busy
);

   localparam int MAX_CYCLES = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
   localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
   localparam int BUS_W      = NUM_SLOTS * CH;

   seq_state_t           state_q, state_n;
   logic                 init_done_q;
   logic [SLOT_W-1:0]    cur_slot_q;
   logic [CH-1:0]        cur_oe_q, cur_ie_q;
   logic [BUS_W-1:0]     oe_q, ie_q, oe_n, ie_n;
   logic [NUM_SLOTS-1:0] fault_q, fault_set;
   logic [NUM_SLOTS-1:0] err_meta_q, err_sync_q;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_val;
   logic                 timer_zero;
   logic                 transfer;
   logic                 slot_bad;
   logic                 in_seq;
   int                   cur_base;

   assign transfer = req_valid && req_ready;
   assign slot_bad = ({1'b0, req_slot} >= (SLOT_W+1)'(NUM_SLOTS));
   assign in_seq   = (state_q != IDLE) && (state_q != REJECT);
   assign cur_base = slot_slice(cur_slot_q);

   ibpl_seq_timer #(
      .W(TIMER_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   // State, enables, faults and the plugin_error synchroniser. init_done_q
   // keeps req_ready low until the first clock after reset is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         init_done_q <= 1'b0;
         oe_q        <= '0;
         ie_q        <= '0;
         fault_q     <= '0;
         err_meta_q  <= '0;
         err_sync_q  <= '0;
      end else begin
         state_q     <= state_n;
         init_done_q <= 1'b1;
         oe_q        <= oe_n;
         ie_q        <= ie_n;
         fault_q     <= (fault_q & ~fault_clr) | fault_set;
         err_meta_q  <= plugin_error;
         err_sync_q  <= err_meta_q;
      end
   end

   // Request fields are held for the whole sequence once accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_slot_q <= '0;
         cur_oe_q   <= '0;
         cur_ie_q   <= '0;
      end else if (transfer) begin
         cur_slot_q <= req_slot;
         cur_oe_q   <= req_oe;
         cur_ie_q   <= req_ie;
      end
   end

   // Next state, response and next enables. The sequenced slot is only
   // touched by its own phase actions; every other slot is watched for
   // plugin_error and shut off if it reports one. The sequenced slot's own
   // error only counts during CHECK, where it aborts into FAULT.
   always_comb begin
      state_n    = state_q;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      timer_load = 1'b0;
      timer_val  = '0;
      oe_n       = oe_q;
      ie_n       = ie_q;
      fault_set  = '0;

      case (state_q)
         IDLE: begin
            if (transfer) begin
               if (slot_bad || fault_q[req_slot]) begin
                  state_n = REJECT;
               end else begin
                  state_n = DROP;
               end
            end
         end
         REJECT: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_n    = IDLE;
         end
         DROP: begin
            oe_n[cur_base +: CH] = oe_q[cur_base +: CH] & cur_oe_q;
            timer_load = 1'b1;
            timer_val  = TIMER_W'(SETTLE_CYCLES - 1);
            state_n    = SETTLE_A;
         end
         SETTLE_A: begin
            if (timer_zero) begin
               state_n = SWITCH;
            end
         end
         SWITCH: begin
            ie_n[cur_base +: CH] = cur_ie_q;
            timer_load = 1'b1;
            timer_val  = TIMER_W'(SETTLE_CYCLES - 1);
            state_n    = SETTLE_B;
         end
         SETTLE_B: begin
            if (timer_zero) begin
               state_n = RAISE;
            end
         end
         RAISE: begin
            oe_n[cur_base +: CH] = cur_oe_q;
            timer_load = 1'b1;
            timer_val  = TIMER_W'(CHECK_CYCLES - 1);
            state_n    = CHECK;
         end
         CHECK: begin
            if (err_sync_q[cur_slot_q]) begin
               oe_n[cur_base +: CH]  = '0;
               ie_n[cur_base +: CH]  = '0;
               fault_set[cur_slot_q] = 1'b1;
               state_n               = FAULT;
            end else if (timer_zero) begin
               state_n = DONE;
            end
         end
         DONE: begin
            resp_valid = 1'b1;
            state_n    = IDLE;
         end
         FAULT: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_n    = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (err_sync_q[s] && !(in_seq && (s == int'(cur_slot_q)))) begin
            oe_n[s*CH +: CH] = '0;
            ie_n[s*CH +: CH] = '0;
            fault_set[s]     = 1'b1;
         end
      end
   end

   assign req_ready     = (state_q == IDLE) && init_done_q;
   assign busy          = (state_q != IDLE);
   assign output_enable = oe_q;
   assign input_enable  = ie_q;
   assign fault_mask    = fault_q;

endmodule

// File: tb/tb_ibpl_enable_sequencer.sv
// tb_ibpl_enable_sequencer
//   Directed and randomized requests against ibpl_enable_sequencer. The
//   reference model keeps per-slot enable and fault arrays and derives the
//   expected enables of any cycle from the phase lengths. Cycle numbering:
//   the transfer cycle is cycle 0, the first cycle after the transfer edge is
//   cycle 1, so a clean response lands in cycle 2*S + C + 4.
module tb_ibpl_enable_sequencer;

   localparam int S   = 16;
   localparam int C   = 8;
   localparam int NS  = 4;
   localparam int CHN = 6;
   localparam int LAT = 2*S + C + 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_slot;
   logic [CHN-1:0]  req_oe, req_ie;
   logic            resp_valid, resp_err;
   logic [NS-1:0]   fault_clr, fault_mask, plugin_error;
   logic [NS*CHN-1:0] output_enable, input_enable;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [CHN-1:0] m_oe [NS];
   logic [CHN-1:0] m_ie [NS];
   logic           m_fault [NS];

   ibpl_enable_sequencer #(
      .SETTLE_CYCLES(S),
      .CHECK_CYCLES (C)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_slot      (req_slot),
      .req_oe        (req_oe),
      .req_ie        (req_ie),
      .resp_valid    (resp_valid),
      .resp_err      (resp_err),
      .fault_clr     (fault_clr),
      .fault_mask    (fault_mask),
      .plugin_error  (plugin_error),
      .output_enable (output_enable),
      .input_enable  (input_enable),
      .busy          (busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [NS*CHN-1:0] modelOeBus();
      logic [NS*CHN-1:0] b;
      for (int s = 0; s < NS; s++) b[s*CHN +: CHN] = m_oe[s];
      return b;
   endfunction

   function automatic logic [NS*CHN-1:0] modelIeBus();
      logic [NS*CHN-1:0] b;
      for (int s = 0; s < NS; s++) b[s*CHN +: CHN] = m_ie[s];
      return b;
   endfunction

   function automatic logic [NS-1:0] modelFault();
      logic [NS-1:0] f;
      for (int s = 0; s < NS; s++) f[s] = m_fault[s];
      return f;
   endfunction

   function automatic void modelReset();
      for (int s = 0; s < NS; s++) begin
         m_oe[s]    = '0;
         m_ie[s]    = '0;
         m_fault[s] = 1'b0;
      end
   endfunction

   // Present a request and hold it until it transfers; returns in cycle 1.
   task automatic applyStimulus(input int slot, input logic [CHN-1:0] oe, input logic [CHN-1:0] ie);
      int guard = 0;
      req_slot  = 2'(slot);
      req_oe    = oe;
      req_ie    = ie;
      req_valid = 1'b1;
      while (!req_ready && guard < 200) begin
         step();
         guard++;
      end
      checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
   endtask

   // Full request with the outcome (clean or reject) predicted by the model.
   task automatic doRequest(input int slot, input logic [CHN-1:0] oe, input logic [CHN-1:0] ie);
      logic [NS*CHN-1:0] exp_oe, exp_ie;
      logic [CHN-1:0]    old_oe, old_ie;
      old_oe = m_oe[slot];
      old_ie = m_ie[slot];
      applyStimulus(slot, oe, ie);
      if (m_fault[slot]) begin
         checkOutput("rej_valid", 32'(resp_valid), 32'd1);
         checkOutput("rej_err", 32'(resp_err), 32'd1);
         checkOutput("rej_oe", 32'(output_enable), 32'(modelOeBus()));
         checkOutput("rej_ie", 32'(input_enable), 32'(modelIeBus()));
         step();
         checkOutput("rej_idle_valid", 32'(resp_valid), 32'd0);
         checkOutput("rej_idle_ready", 32'(req_ready), 32'd1);
      end else begin
         for (int k = 1; k <= LAT; k++) begin
            exp_oe = modelOeBus();
            exp_ie = modelIeBus();
            exp_oe[slot*CHN +: CHN] = (k < 2) ? old_oe : (k < 2*S + 4) ? (old_oe & oe) : oe;
            exp_ie[slot*CHN +: CHN] = (k < S + 3) ? old_ie : ie;
            if (k == 1 || k == 2 || k == S+2 || k == S+3 || k == 2*S+3 || k == 2*S+4 || k == LAT) begin
               checkOutput($sformatf("seq_oe_c%0d", k), 32'(output_enable), 32'(exp_oe));
               checkOutput($sformatf("seq_ie_c%0d", k), 32'(input_enable), 32'(exp_ie));
               checkOutput($sformatf("seq_busy_c%0d", k), 32'(busy), 32'd1);
            end
            checkOutput($sformatf("seq_resp_valid_c%0d", k), 32'(resp_valid), 32'(k == LAT));
            if (k == LAT) checkOutput("seq_resp_err", 32'(resp_err), 32'd0);
            if (k < LAT) step();
         end
         m_oe[slot] = oe;
         m_ie[slot] = ie;
         step();
         checkOutput("seq_end_busy", 32'(busy), 32'd0);
         checkOutput("seq_end_ready", 32'(req_ready), 32'd1);
      end
   endtask

   // Request whose slot reports plugin_error for one cycle, 3 cycles into
   // CHECK. The 2-FF synchroniser makes it visible two cycles later and the
   // fault response follows one cycle after that.
   task automatic faultRequest(input int slot, input logic [CHN-1:0] oe, input logic [CHN-1:0] ie);
      int pk;
      int fk;
      logic [NS*CHN-1:0] exp_oe, exp_ie;
      logic [NS-1:0]     exp_f;
      pk = 2*S + 4 + 3;
      fk = pk + 3;
      applyStimulus(slot, oe, ie);
      for (int k = 1; k <= fk; k++) begin
         if (k == pk) plugin_error[slot] = 1'b1;
         if (k == pk + 1) plugin_error[slot] = 1'b0;
         if (k == 2*S + 4) checkOutput("flt_raised", 32'(output_enable[slot*CHN +: CHN]), 32'(oe));
         checkOutput($sformatf("flt_resp_valid_c%0d", k), 32'(resp_valid), 32'(k == fk));
         if (k < fk) step();
      end
      m_oe[slot]    = '0;
      m_ie[slot]    = '0;
      m_fault[slot] = 1'b1;
      exp_oe = modelOeBus();
      exp_ie = modelIeBus();
      exp_f  = modelFault();
      checkOutput("flt_resp_err", 32'(resp_err), 32'd1);
      checkOutput("flt_oe", 32'(output_enable), 32'(exp_oe));
      checkOutput("flt_ie", 32'(input_enable), 32'(exp_ie));
      checkOutput("flt_mask", 32'(fault_mask), 32'(exp_f));
      step();
      checkOutput("flt_end_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int ready_cnt, resp_cnt, tk;
      int rslot;
      logic [CHN-1:0] a_oe, a_ie, b_oe, b_ie;

      reset        = 1'b1;
      req_valid    = 1'b0;
      req_slot     = '0;
      req_oe       = '0;
      req_ie       = '0;
      fault_clr    = '0;
      plugin_error = '0;
      modelReset();

      // Reset state.
      step(); step(); step();
      checkOutput("rst_oe", 32'(output_enable), 32'd0);
      checkOutput("rst_ie", 32'(input_enable), 32'd0);
      checkOutput("rst_mask", 32'(fault_mask), 32'd0);
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_resp", 32'(resp_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("rel_ready_before_clk", 32'(req_ready), 32'd0);
      step();
      checkOutput("rel_ready_after_clk", 32'(req_ready), 32'd1);

      // First apply and an incremental change on slot 1.
      doRequest(1, 6'h3F, 6'h00);
      checkOutput("slot1_oe_3f", 32'(output_enable[11:6]), 32'h3F);
      doRequest(1, 6'h0F, 6'h30);

      // Fault on slot 2, reject while faulted, clear, then accept.
      faultRequest(2, 6'h2D, 6'h12);
      doRequest(2, 6'h11, 6'h22);
      fault_clr[2] = 1'b1;
      step();
      fault_clr[2] = 1'b0;
      m_fault[2] = 1'b0;
      checkOutput("clr2_mask", 32'(fault_mask), 32'(modelFault()));
      doRequest(2, 6'h11, 6'h22);

      // Identical request still runs the full sequence.
      doRequest(2, 6'h11, 6'h22);

      // req_valid held across a sequence: B must transfer exactly once.
      a_oe = 6'(($urandom % 63) + 1);
      a_ie = 6'($urandom);
      b_oe = 6'(($urandom % 63) + 1);
      b_ie = 6'($urandom);
      applyStimulus(3, a_oe, a_ie);
      req_slot  = 2'd0;
      req_oe    = b_oe;
      req_ie    = b_ie;
      req_valid = 1'b1;
      ready_cnt = 0;
      resp_cnt  = 0;
      tk        = -1;
      for (int k = 1; k <= 2*LAT + 5; k++) begin
         logic take;
         if (resp_valid) resp_cnt++;
         if (req_ready && k <= 2*LAT + 1) ready_cnt++;
         if (k == LAT) checkOutput("b2b_a_resp", 32'(resp_valid), 32'd1);
         if (k == 2*LAT + 1) begin
            checkOutput("b2b_b_resp", 32'(resp_valid), 32'd1);
            checkOutput("b2b_b_err", 32'(resp_err), 32'd0);
         end
         take = req_ready && req_valid;
         step();
         if (take) begin
            req_valid = 1'b0;
            tk = k;
         end
      end
      req_valid = 1'b0;
      m_oe[3] = a_oe; m_ie[3] = a_ie;
      m_oe[0] = b_oe; m_ie[0] = b_ie;
      checkOutput("b2b_transfer_cycle", 32'(tk), 32'(LAT + 1));
      checkOutput("b2b_ready_cycles", 32'(ready_cnt), 32'd1);
      checkOutput("b2b_resp_count", 32'(resp_cnt), 32'd2);
      checkOutput("b2b_oe", 32'(output_enable), 32'(modelOeBus()));
      checkOutput("b2b_ie", 32'(input_enable), 32'(modelIeBus()));

      // plugin_error on an idle slot: fault two sync stages later.
      plugin_error[0] = 1'b1;
      step();
      plugin_error[0] = 1'b0;
      step();
      checkOutput("idle_err_not_yet", 32'(fault_mask), 32'(modelFault()));
      step();
      m_oe[0] = '0; m_ie[0] = '0; m_fault[0] = 1'b1;
      checkOutput("idle_err_mask", 32'(fault_mask), 32'(modelFault()));
      checkOutput("idle_err_oe", 32'(output_enable), 32'(modelOeBus()));
      checkOutput("idle_err_ie", 32'(input_enable), 32'(modelIeBus()));

      // Set and clear in the same cycle on slot 3: set wins.
      plugin_error[3] = 1'b1;
      step(); step(); step();
      m_oe[3] = '0; m_ie[3] = '0; m_fault[3] = 1'b1;
      checkOutput("setwin_pre", 32'(fault_mask), 32'(modelFault()));
      fault_clr[3] = 1'b1;
      step();
      fault_clr[3] = 1'b0;
      checkOutput("setwin_mask", 32'(fault_mask), 32'(modelFault()));
      plugin_error[3] = 1'b0;
      step(); step(); step();
      checkOutput("sticky_mask", 32'(fault_mask), 32'(modelFault()));
      fault_clr[3] = 1'b1;
      step();
      fault_clr[3] = 1'b0;
      m_fault[3] = 1'b0;
      checkOutput("clr3_mask", 32'(fault_mask), 32'(modelFault()));

      // Randomized requests; slot 0 is still faulted, so some are rejects.
      for (int i = 0; i < 6; i++) begin
         rslot = int'($urandom_range(0, NS - 1));
         doRequest(rslot, 6'($urandom), 6'($urandom));
      end

      // Reset in the middle of SETTLE_B.
      applyStimulus(1, 6'h15, 6'h2A);
      for (int k = 1; k < S + 10; k++) step();
      #1;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("midrst_oe", 32'(output_enable), 32'(modelOeBus()));
      checkOutput("midrst_ie", 32'(input_enable), 32'(modelIeBus()));
      checkOutput("midrst_mask", 32'(fault_mask), 32'(modelFault()));
      checkOutput("midrst_resp", 32'(resp_valid), 32'd0);
      checkOutput("midrst_ready", 32'(req_ready), 32'd0);
      step();
      checkOutput("midrst_resp_hold", 32'(resp_valid), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("midrst_rel_ready0", 32'(req_ready), 32'd0);
      step();
      checkOutput("midrst_rel_ready1", 32'(req_ready), 32'd1);
      checkOutput("midrst_rel_resp", 32'(resp_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
